float_divider: RTL and testbench



---
 rtl/float_pkg.sv | 40 ++++
 rtl/float_divider_div_step.sv | 19 +
 rtl/float_divider.sv | 88 ++++++++
 tb/tb_float_divider.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared types and helpers for the binary32 float datapath.
// Simplified number model: hidden bit always 1, no special values.
package float_pkg;

    localparam logic [7:0] EXP_BIAS  = 8'd127;
    localparam int         MANT_W    = 23;
    localparam int         DIV_ITERS = 25;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] ea;
        logic [7:0] eb;
    } div_hdr_t;

    // Normalise a 25-bit quotient in [0.5, 2) into a truncated binary32
    // word; every discarded bit and the remainder jam into the LSB.
    function automatic logic [31:0] pack_quot(
        input div_hdr_t    hdr,
        input logic [24:0] q,
        input logic        sticky
    );
        logic [MANT_W-1:0] mant;
        logic [7:0]        exp;
        if (q[24]) begin
            mant = {q[23:2], q[1] | q[0] | sticky};
            exp  = hdr.ea - hdr.eb + EXP_BIAS;
        end else begin
            mant = {q[22:1], q[0] | sticky};
            exp  = hdr.ea - hdr.eb + EXP_BIAS - 8'd1;
        end
        return {hdr.sign, exp, mant};
    endfunction

endpackage

// File: rtl/float_divider_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift.
// Produces one quotient bit per call.
module mantissa_div_step
    import float_pkg::*;
(
    input  logic [24:0] r,
    input  logic [23:0] d,
    output logic        qbit,
    output logic [24:0] r_next
);

    logic [23:0] diff;

    // When r >= d the difference is below d, so 24 bits hold it exactly.
    assign qbit   = (r >= {1'b0, d});
    assign diff   = r[23:0] - d;
    assign r_next = qbit ? {diff, 1'b0} : {r[23:0], 1'b0};

endmodule

// File: rtl/float_divider.sv
// Sequential binary32 divider: 25 restoring iterations, one bit per clock,
// with a Start/Busy/Done handshake.
module float_divider
    import float_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result
);

    localparam logic [4:0] LAST_BIT = 5'(DIV_ITERS - 1);

    state_t      state;
    logic [4:0]  count;
    logic [24:0] rem;
    logic [23:0] dmant;
    logic [24:0] quot;
    div_hdr_t    hdr;

    logic        qbit;
    logic [24:0] rem_next;
    logic [24:0] quot_next;

    mantissa_div_step u_step (
        .r      (rem),
        .d      (dmant),
        .qbit   (qbit),
        .r_next (rem_next)
    );

    always_comb begin
        quot_next        = quot;
        quot_next[count] = qbit;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            count  <= '0;
            rem    <= '0;
            dmant  <= '0;
            quot   <= '0;
            hdr    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Result <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        hdr.sign <= Dividend[31] ^ Divisor[31];
                        hdr.ea   <= Dividend[30:23];
                        hdr.eb   <= Divisor[30:23];
                        rem      <= {2'b01, Dividend[MANT_W-1:0]};
                        dmant    <= {1'b1, Divisor[MANT_W-1:0]};
                        quot     <= '0;
                        count    <= LAST_BIT;
                        Busy     <= 1'b1;
                        state    <= DIVIDE;
                    end else begin
                        state <= IDLE;
                    end
                end
                DIVIDE: begin
                    quot <= quot_next;
                    rem  <= rem_next;
                    if (count == 5'd0) begin
                        // Final bit lands this edge; sticky is the final remainder.
                        Result <= pack_quot(hdr, quot_next, |rem_next);
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider against an integer-division model.
// Directed, random, back-to-back and reset-abort scenarios.
module tb_float_divider;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int nvec;
    int nerr;

    float_divider dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Quotient of the 24-bit significands scaled by 2^24, truncated to
    // 24 significant bits with all lost information jammed into the LSB.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, num, q, rem, kept, lost;
        int              shift, e;
        logic [22:0]     mant;
        logic [7:0]      exp;
        ma    = {40'd0, 1'b1, a[22:0]};
        mb    = {40'd0, 1'b1, b[22:0]};
        num   = ma << 24;
        q     = num / mb;
        rem   = num % mb;
        shift = (q >= 64'h100_0000) ? 1 : 0;
        kept  = q >> shift;
        lost  = q & ((64'd1 << shift) - 64'd1);
        mant  = kept[22:0] | 23'((lost != 0 || rem != 0) ? 1 : 0);
        e     = int'(a[30:23]) - int'(b[30:23]) + 126 + shift;
        exp   = e[7:0];
        return {a[31] ^ b[31], exp, mant};
    endfunction

    // Issue one request; report latency to Done (-1 if none within bound)
    // and whether Busy/Result behaved while iterating.
    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat, output bit hs_ok);
        logic [31:0] held;
        @(negedge Clk);
        Start    = 1'b1;
        Dividend = a;
        Divisor  = b;
        held     = Result;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        Dividend = $urandom;
        Divisor  = $urandom;
        lat   = -1;
        hs_ok = 1'b1;
        res   = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (Done) begin
                if (Busy) hs_ok = 1'b0;
                res = Result;
                lat = i;
                break;
            end
            if (!Busy || Result !== held) hs_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        Rst_n    = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(negedge Clk);
        nvec++;
        if (Busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy got %b want 0", Busy);
        end
        nvec++;
        if (Done !== 1'b0) begin
            nerr++;
            $display("FAIL reset_done got %b want 0", Done);
        end
        nvec++;
        if (Result !== 32'h0) begin
            nerr++;
            $display("FAIL reset_result got %h want 00000000", Result);
        end
        Rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] a_tab [3] = '{32'h40C00000, 32'h3F800000, 32'hC0F00000};
        logic [31:0] b_tab [3] = '{32'h40000000, 32'h40400000, 32'h40200000};
        logic [31:0] e_tab [3] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000};
        logic [31:0] res;
        int          lat;
        bit          ok;
        for (int i = 0; i < 3; i++) begin
            op(a_tab[i], b_tab[i], res, lat, ok);
            nvec++;
            if (res !== e_tab[i]) begin
                nerr++;
                $display("FAIL directed_%0d result got %h want %h", i, res, e_tab[i]);
            end
            nvec++;
            if (lat !== 26) begin
                nerr++;
                $display("FAIL directed_%0d latency got %0d want 26", i, lat);
            end
            nvec++;
            if (ok !== 1'b1) begin
                nerr++;
                $display("FAIL directed_%0d handshake got %b want 1", i, ok);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          ok;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            exp = ref_div(a, b);
            op(a, b, res, lat, ok);
            nvec++;
            if (res !== exp || lat !== 26 || ok !== 1'b1) begin
                nerr++;
                $display("FAIL random_%0d %h/%h got %h lat %0d hs %b want %h lat 26 hs 1",
                         i, a, b, res, lat, ok, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          done_cyc [$];
        logic [31:0] done_res [$];
        bit          overlap;
        @(negedge Clk);
        Start    = 1'b1;
        Dividend = 32'h3F800000;
        Divisor  = 32'h3FC00000;
        @(posedge Clk);
        overlap = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge Clk);
            if (Busy && Done) overlap = 1'b1;
            if (c == 1) begin
                Dividend = 32'h40C00000;
                Divisor  = 32'h40000000;
            end
            if (Done) begin
                done_cyc.push_back(c);
                done_res.push_back(Result);
                if (done_cyc.size() == 1) begin
                    // Only the DONE-cycle operands get sampled; these must win.
                    Dividend = 32'h40C00000;
                    Divisor  = 32'h40000000;
                end else begin
                    Start = 1'b0;
                    break;
                end
            end else if (c > 1 && c != 26) begin
                Dividend = $urandom;
                Divisor  = $urandom;
            end
        end
        Start = 1'b0;
        nvec++;
        if (done_cyc.size() !== 2) begin
            nerr++;
            $display("FAIL b2b_done_count got %0d want 2", done_cyc.size());
        end else begin
            nvec++;
            if (done_cyc[0] !== 26 || done_cyc[1] !== 52) begin
                nerr++;
                $display("FAIL b2b_done_cycles got %0d,%0d want 26,52", done_cyc[0], done_cyc[1]);
            end
            nvec++;
            if (done_res[0] !== 32'h3F2AAAAB) begin
                nerr++;
                $display("FAIL b2b_first got %h want 3f2aaaab", done_res[0]);
            end
            nvec++;
            if (done_res[1] !== 32'h40400000) begin
                nerr++;
                $display("FAIL b2b_second got %h want 40400000", done_res[1]);
            end
        end
        nvec++;
        if (overlap !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_busy_done_overlap got %b want 0", overlap);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        int          lat;
        bit          ok;
        bit          spurious;
        @(negedge Clk);
        Start    = 1'b1;
        Dividend = 32'h40C00000;
        Divisor  = 32'h40000000;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (10) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        nvec++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'h0) begin
            nerr++;
            $display("FAIL abort_outputs got busy %b done %b result %h want 0 0 00000000",
                     Busy, Done, Result);
        end
        repeat (2) @(negedge Clk);
        Rst_n    = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (Done || Busy || Result !== 32'h0) spurious = 1'b1;
        end
        nvec++;
        if (spurious !== 1'b0) begin
            nerr++;
            $display("FAIL abort_quiet got activity %b want 0", spurious);
        end
        op(32'h40C00000, 32'h40000000, res, lat, ok);
        nvec++;
        if (res !== 32'h40400000 || lat !== 26 || ok !== 1'b1) begin
            nerr++;
            $display("FAIL abort_restart got %h lat %0d hs %b want 40400000 lat 26 hs 1",
                     res, lat, ok);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
